conv_tile_scheduler: RTL and testbench
======================================

Name: conv_tile_scheduler

Overview:
Sequences a full valid-mode 2-D convolution over the tensor_processing_unit (TPU). It enumerates every output position of an IMAGE_WIDTH x IMAGE_HEIGHT image for a k x k kernel and packs the positions into batches of up to NUM_UNITS. For each batch it programs the TPU's per-unit window start addresses, pulses start, waits for done, and streams the captured ReLU results out in raster order through a valid/ready port. It sits between the layer-level control and the TPU.

Parameters:
- DATA_WIDTH, 16: result word width; matches TPU.
- IMAGE_WIDTH, 5: image columns.
- IMAGE_HEIGHT, 5: image rows.
- NUM_UNITS, 9: TPU MAC/ReLU lanes.
- Derived: ADDR_W = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT); KW = $clog2(IMAGE_WIDTH); LEN_W = (KW-1)*(KW-1)+1, which equals the TPU length port width.

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- job_start, in, 1: one-cycle request; sampled only in IDLE.
- job_kernel_dim, in, KW: kernel side k.
- job_kernel_base, in, ADDR_W: kernel base address in mem2.
- job_bias_base, in, ADDR_W: bias address.
- busy, out, 1: high whenever the FSM is not in IDLE.
- job_done, out, 1: one-cycle pulse after the last result is accepted.
- job_error, out, 1: one-cycle pulse when a job is rejected.
- tpu_start, out, 1: one-cycle start pulse to the TPU.
- tpu_active_units, out, NUM_UNITS: lane enables.
- tpu_start_addr_1, out, NUM_UNITS x ADDR_W: per-lane window top-left address.
- tpu_start_addr_2, out, NUM_UNITS x ADDR_W: per-lane kernel address.
- tpu_bias_addr, out, NUM_UNITS x ADDR_W: per-lane bias address.
- tpu_kernel_dim, out, KW: kernel side to TPU.
- tpu_length, out, LEN_W: k*k.
- tpu_done, in, 1: TPU completion.
- tpu_relu_out, in, NUM_UNITS x DATA_WIDTH: TPU results.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream ready.
- out_data, out, DATA_WIDTH: result value.
- out_index, out, ADDR_W: linear output index, r*OW + c.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters and buffers cleared. Reset mid-job aborts immediately, with no job_done and no job_error.
- Output grid: OW = IMAGE_WIDTH-k+1, OH = IMAGE_HEIGHT-k+1, TOTAL = OW*OH. Position (r,c) has window address r*IMAGE_WIDTH + c.
- IDLE:
  - On job_start, latch k, job_kernel_base and job_bias_base.
  - If k==0 or k>min(IMAGE_WIDTH, IMAGE_HEIGHT): pulse job_error the next cycle and stay in IDLE.
  - Otherwise clear r, c, out_index and row_base, then go to GEN.
- GEN (one lane per cycle, lane j starting at 0):
  - Write tpu_start_addr_1[j] = row_base + c and set active[j].
  - Advance position: if c==OW-1 then c=0, r++, row_base += IMAGE_WIDTH; else c++.
  - Leave GEN when j==NUM_UNITS-1 or the last position has been generated. Go to ISSUE.
  - Unused lanes keep addr 0 and active 0.
  - Every active lane gets start_addr_2 = kernel_base and bias_addr = bias_base.
- ISSUE: assert tpu_start for exactly one cycle, then go to WAIT.
  - tpu_kernel_dim = k and tpu_length = k*k, held stable from GEN until the batch drains.
- WAIT: on tpu_done, capture tpu_relu_out into the result buffer and go to DRAIN. tpu_done in any other state is ignored.
- DRAIN:
  - Present buffer[lane] on out_data with out_valid=1 and the current out_index.
  - On out_valid && out_ready, advance lane and out_index.
  - out_data and out_index stay stable while out_ready is low.
  - After the last active lane: if out_index==TOTAL go to DONE, else clear the active mask and go to GEN.
- DONE: pulse job_done for one cycle, then go to IDLE.
- Overlap rules:
  - job_start while busy is ignored.
  - Cycle in which job_done is high: job_start is ignored (FSM not yet in IDLE).

Decomposition:
- Package tpu_sched_pkg holds: state enum (IDLE, GEN, ISSUE, WAIT, DRAIN, DONE) and the width helper functions for ADDR_W, KW and LEN_W.
- One sub-module, conv_pos_counter, owns r, c and row_base, with advance/clear inputs and a last flag.

Test Plan:
- 5x5 image, k=3:
  - GEN yields start_addr_1 lanes 0..8 = {0,1,2,5,6,7,10,11,12}, active=9'h1FF, length=9, one tpu_start.
  - Stub TPU returns lane i value 100+i; outputs are index 0..8 with data 100..108; then job_done.
- k=2 (TOTAL=16):
  - Batch 1: lanes 0..8 = {0,1,2,3,5,6,7,8,10}, active 9'h1FF.
  - Batch 2: lanes 0..6 = {11,12,13,15,16,17,18}, active 9'h07F.
  - 16 outputs; two tpu_start pulses.
- k=5: single batch, active 9'h001, addr 0, length 25; one output, index 0.
- k=0 and k=6: job_error pulses, no tpu_start, busy stays 0.
- Back-pressure: k=3 with out_ready toggling 1,0,0,1 …; no result lost or duplicated, data held while stalled, ordering 0..8 preserved.
- Robustness:
  - Assert reset during WAIT: all outputs 0 next cycle, no job_done.
  - Spurious tpu_done in IDLE: ignored.
  - job_start while busy: ignored.

Source files
------------

// File: rtl/tpu_sched_pkg.sv
// Shared types and width helpers for the convolution tile scheduler.
// The helpers keep every derived width in one place so the top and its counter agree.
package tpu_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GEN   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } state_e;

  function automatic int calc_addr_w(input int width, input int height);
    return $clog2(width * height);
  endfunction

  function automatic int calc_kw(input int width);
    return $clog2(width);
  endfunction

  function automatic int calc_len_w(input int width);
    return (calc_kw(width) - 1) * (calc_kw(width) - 1) + 1;
  endfunction

  function automatic int calc_lane_w(input int num_units);
    return (num_units > 1) ? $clog2(num_units) : 1;
  endfunction

endpackage

// File: rtl/conv_pos_counter.sv
// Raster walker over the output grid: tracks row, column and the row's base address.
// o_addr is the top-left window address of the current output position.
module conv_pos_counter #(
  parameter int IMAGE_WIDTH = 5,
  parameter int ADDR_W      = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_advance,
  input  logic [ADDR_W-1:0] i_ow,
  input  logic [ADDR_W-1:0] i_oh,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMAGE_WIDTH);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [ADDR_W-1:0] r_row;
  logic [ADDR_W-1:0] r_col;
  logic [ADDR_W-1:0] r_row_base;
  logic              w_col_end;

  assign w_col_end = (r_col == (i_ow - ONE));
  assign o_last    = w_col_end && (r_row == (i_oh - ONE));
  assign o_addr    = r_row_base + r_col;

  // Position registers: wrap the column at the row end and step the base by one image row.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_row      <= ADDR_ZERO;
      r_col      <= ADDR_ZERO;
      r_row_base <= ADDR_ZERO;
    end else if (i_clear) begin
      r_row      <= ADDR_ZERO;
      r_col      <= ADDR_ZERO;
      r_row_base <= ADDR_ZERO;
    end else if (i_advance) begin
      if (w_col_end) begin
        r_col      <= ADDR_ZERO;
        r_row      <= r_row + ONE;
        r_row_base <= r_row_base + ROW_STEP;
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Batches every valid-mode output position of a k x k convolution onto the TPU lanes,
// runs each batch and streams the ReLU results out in raster order over valid/ready.
module conv_tile_scheduler
  import tpu_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int NUM_UNITS    = 9,
  parameter int ADDR_W       = calc_addr_w(IMAGE_WIDTH, IMAGE_HEIGHT),
  parameter int KW           = calc_kw(IMAGE_WIDTH),
  parameter int LEN_W        = calc_len_w(IMAGE_WIDTH)
) (
  input  logic                                  i_clk,
  input  logic                                  i_reset,
  input  logic                                  i_job_start,
  input  logic [KW-1:0]                         i_job_kernel_dim,
  input  logic [ADDR_W-1:0]                     i_job_kernel_base,
  input  logic [ADDR_W-1:0]                     i_job_bias_base,
  output logic                                  o_busy,
  output logic                                  o_job_done,
  output logic                                  o_job_error,
  output logic                                  o_tpu_start,
  output logic [NUM_UNITS-1:0]                  o_tpu_active_units,
  output logic [NUM_UNITS-1:0][ADDR_W-1:0]      o_tpu_start_addr_1,
  output logic [NUM_UNITS-1:0][ADDR_W-1:0]      o_tpu_start_addr_2,
  output logic [NUM_UNITS-1:0][ADDR_W-1:0]      o_tpu_bias_addr,
  output logic [KW-1:0]                         o_tpu_kernel_dim,
  output logic [LEN_W-1:0]                      o_tpu_length,
  input  logic                                  i_tpu_done,
  input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]  i_tpu_relu_out,
  output logic                                  o_out_valid,
  input  logic                                  i_out_ready,
  output logic [DATA_WIDTH-1:0]                 o_out_data,
  output logic [ADDR_W-1:0]                     o_out_index
);

  localparam int LANE_W  = calc_lane_w(NUM_UNITS);
  localparam int CNT_W   = ADDR_W + 1;
  localparam int MIN_DIM = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;

  localparam logic [KW:0]                     K_MAX      = (KW+1)'(MIN_DIM);
  localparam logic [KW-1:0]                   K_ZERO     = {KW{1'b0}};
  localparam logic [LANE_W-1:0]               LANE_LAST  = LANE_W'(NUM_UNITS - 1);
  localparam logic [LANE_W-1:0]               LANE_ONE   = LANE_W'(1);
  localparam logic [LANE_W-1:0]               LANE_ZERO  = {LANE_W{1'b0}};
  localparam logic [ADDR_W-1:0]               OW_BASE    = ADDR_W'(IMAGE_WIDTH + 1);
  localparam logic [ADDR_W-1:0]               OH_BASE    = ADDR_W'(IMAGE_HEIGHT + 1);
  localparam logic [ADDR_W-1:0]               ADDR_ZERO  = {ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]                CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]                CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [LEN_W-1:0]                LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [NUM_UNITS-1:0]            MASK_ZERO  = {NUM_UNITS{1'b0}};
  localparam logic [NUM_UNITS*ADDR_W-1:0]     ARR_ZERO   = {(NUM_UNITS*ADDR_W){1'b0}};
  localparam logic [NUM_UNITS*DATA_WIDTH-1:0] BUF_ZERO   = {(NUM_UNITS*DATA_WIDTH){1'b0}};
  localparam logic [DATA_WIDTH-1:0]           DATA_ZERO  = {DATA_WIDTH{1'b0}};

  state_e r_state;
  state_e w_next;

  logic [KW-1:0]                        r_k;
  logic [ADDR_W-1:0]                    r_kernel_base;
  logic [ADDR_W-1:0]                    r_bias_base;
  logic [ADDR_W-1:0]                    r_ow;
  logic [ADDR_W-1:0]                    r_oh;
  logic [CNT_W-1:0]                     r_total;
  logic [LEN_W-1:0]                     r_len;
  logic [LANE_W-1:0]                    r_lane;
  logic [LANE_W-1:0]                    r_last_lane;
  logic [NUM_UNITS-1:0]                 r_active;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]     r_addr1;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]     r_addr2;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]     r_bias;
  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0] r_buf;
  logic [CNT_W-1:0]                     r_out_idx;
  logic [DATA_WIDTH-1:0]                r_out_data;
  logic                                 r_busy;
  logic                                 r_job_done;
  logic                                 r_job_error;
  logic                                 r_tpu_start;
  logic                                 r_out_valid;

  logic              w_k_ok;
  logic              w_accept;
  logic              w_reject;
  logic [ADDR_W-1:0] w_k_addr;
  logic [LEN_W-1:0]  w_k_len;
  logic [ADDR_W-1:0] w_ow;
  logic [ADDR_W-1:0] w_oh;
  logic [CNT_W-1:0]  w_total;
  logic [LEN_W-1:0]  w_len;
  logic [ADDR_W-1:0] w_pos_addr;
  logic              w_pos_last;
  logic              w_gen_step;
  logic              w_gen_end;
  logic              w_drain_fire;
  logic              w_batch_end;
  logic [CNT_W-1:0]  w_idx_next;

  assign w_k_ok       = (i_job_kernel_dim != K_ZERO) && ({1'b0, i_job_kernel_dim} <= K_MAX);
  assign w_accept     = (r_state == IDLE) && i_job_start && w_k_ok;
  assign w_reject     = (r_state == IDLE) && i_job_start && !w_k_ok;
  assign w_k_addr     = {{(ADDR_W-KW){1'b0}}, i_job_kernel_dim};
  assign w_k_len      = {{(LEN_W-KW){1'b0}}, i_job_kernel_dim};
  assign w_ow         = OW_BASE - w_k_addr;
  assign w_oh         = OH_BASE - w_k_addr;
  assign w_total      = {1'b0, w_ow} * {1'b0, w_oh};
  assign w_len        = w_k_len * w_k_len;
  assign w_gen_step   = (r_state == GEN);
  assign w_gen_end    = (r_lane == LANE_LAST) || w_pos_last;
  assign w_drain_fire = (r_state == DRAIN) && i_out_ready;
  assign w_batch_end  = w_drain_fire && (r_lane == r_last_lane);
  assign w_idx_next   = r_out_idx + CNT_ONE;

  conv_pos_counter #(
    .IMAGE_WIDTH (IMAGE_WIDTH),
    .ADDR_W      (ADDR_W)
  ) u_pos (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (w_accept),
    .i_advance (w_gen_step),
    .i_ow      (r_ow),
    .i_oh      (r_oh),
    .o_addr    (w_pos_addr),
    .o_last    (w_pos_last)
  );

  // Next-state decode for the job sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = GEN; else w_next = IDLE;
      GEN:     if (w_gen_end) w_next = ISSUE; else w_next = GEN;
      ISSUE:   w_next = WAIT;
      WAIT:    if (i_tpu_done) w_next = DRAIN; else w_next = WAIT;
      DRAIN: begin
        if (w_batch_end) begin
          if (w_idx_next == r_total) w_next = DONE; else w_next = GEN;
        end else begin
          w_next = DRAIN;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Status and handshake flags are decoded from the next state so they align with it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_busy      <= 1'b0;
      r_tpu_start <= 1'b0;
      r_job_done  <= 1'b0;
      r_job_error <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_busy      <= (w_next != IDLE);
      r_tpu_start <= (w_next == ISSUE);
      r_job_done  <= (w_next == DONE);
      r_job_error <= w_reject;
      r_out_valid <= (w_next == DRAIN);
    end
  end

  // Job parameters: k and bases latch on any request; grid geometry only for an accepted one.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_k           <= K_ZERO;
      r_kernel_base <= ADDR_ZERO;
      r_bias_base   <= ADDR_ZERO;
      r_ow          <= ADDR_ZERO;
      r_oh          <= ADDR_ZERO;
      r_total       <= CNT_ZERO;
      r_len         <= LEN_ZERO;
    end else if ((r_state == IDLE) && i_job_start) begin
      r_k           <= i_job_kernel_dim;
      r_kernel_base <= i_job_kernel_base;
      r_bias_base   <= i_job_bias_base;
      if (w_k_ok) begin
        r_ow    <= w_ow;
        r_oh    <= w_oh;
        r_total <= w_total;
        r_len   <= w_len;
      end
    end
  end

  // Batch datapath: lane programming, result capture and the result stream.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_lane      <= LANE_ZERO;
      r_last_lane <= LANE_ZERO;
      r_active    <= MASK_ZERO;
      r_addr1     <= ARR_ZERO;
      r_addr2     <= ARR_ZERO;
      r_bias      <= ARR_ZERO;
      r_buf       <= BUF_ZERO;
      r_out_idx   <= CNT_ZERO;
      r_out_data  <= DATA_ZERO;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lane    <= LANE_ZERO;
            r_out_idx <= CNT_ZERO;
            r_active  <= MASK_ZERO;
            r_addr1   <= ARR_ZERO;
            r_addr2   <= ARR_ZERO;
            r_bias    <= ARR_ZERO;
          end
        end
        GEN: begin
          r_addr1[r_lane]  <= w_pos_addr;
          r_addr2[r_lane]  <= r_kernel_base;
          r_bias[r_lane]   <= r_bias_base;
          r_active[r_lane] <= 1'b1;
          if (w_gen_end) begin
            r_last_lane <= r_lane;
            r_lane      <= LANE_ZERO;
          end else begin
            r_lane <= r_lane + LANE_ONE;
          end
        end
        WAIT: begin
          if (i_tpu_done) begin
            r_buf      <= i_tpu_relu_out;
            r_out_data <= i_tpu_relu_out[0];
            r_lane     <= LANE_ZERO;
          end
        end
        DRAIN: begin
          if (w_drain_fire) begin
            r_out_idx <= w_idx_next;
            if (w_batch_end) begin
              r_lane   <= LANE_ZERO;
              r_active <= MASK_ZERO;
              r_addr1  <= ARR_ZERO;
              r_addr2  <= ARR_ZERO;
              r_bias   <= ARR_ZERO;
            end else begin
              r_lane     <= r_lane + LANE_ONE;
              r_out_data <= r_buf[r_lane + LANE_ONE];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy             = r_busy;
  assign o_job_done         = r_job_done;
  assign o_job_error        = r_job_error;
  assign o_tpu_start        = r_tpu_start;
  assign o_tpu_active_units = r_active;
  assign o_tpu_start_addr_1 = r_addr1;
  assign o_tpu_start_addr_2 = r_addr2;
  assign o_tpu_bias_addr    = r_bias;
  assign o_tpu_kernel_dim   = r_k;
  assign o_tpu_length       = r_len;
  assign o_out_valid        = r_out_valid;
  assign o_out_data         = r_out_data;
  assign o_out_index        = r_out_idx[ADDR_W-1:0];

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler: a job table run in a loop against a stub TPU,
// plus hand-written overlap, reset-during-WAIT and spurious-done sequences.
module tb_conv_tile_scheduler;

  localparam int DW = 16;
  localparam int NU = 9;
  localparam int AW = 5;
  localparam int KW = 3;
  localparam int LW = 5;

  logic                   clk = 1'b0;
  logic                   i_reset;
  logic                   i_job_start;
  logic [KW-1:0]          i_job_kernel_dim;
  logic [AW-1:0]          i_job_kernel_base;
  logic [AW-1:0]          i_job_bias_base;
  logic                   o_busy, o_job_done, o_job_error, o_tpu_start;
  logic [NU-1:0]          o_active;
  logic [NU-1:0][AW-1:0]  o_addr1, o_addr2, o_bias;
  logic [KW-1:0]          o_tpu_kernel_dim;
  logic [LW-1:0]          o_tpu_length;
  logic                   i_tpu_done;
  logic                   stub_done, spur_done;
  logic [NU-1:0][DW-1:0]  relu;
  logic                   o_out_valid;
  logic                   i_out_ready;
  logic [DW-1:0]          o_out_data;
  logic [AW-1:0]          o_out_index;

  always #5 clk = ~clk;
  assign i_tpu_done = stub_done | spur_done;

  conv_tile_scheduler dut (
    .i_clk              (clk),
    .i_reset            (i_reset),
    .i_job_start        (i_job_start),
    .i_job_kernel_dim   (i_job_kernel_dim),
    .i_job_kernel_base  (i_job_kernel_base),
    .i_job_bias_base    (i_job_bias_base),
    .o_busy             (o_busy),
    .o_job_done         (o_job_done),
    .o_job_error        (o_job_error),
    .o_tpu_start        (o_tpu_start),
    .o_tpu_active_units (o_active),
    .o_tpu_start_addr_1 (o_addr1),
    .o_tpu_start_addr_2 (o_addr2),
    .o_tpu_bias_addr    (o_bias),
    .o_tpu_kernel_dim   (o_tpu_kernel_dim),
    .o_tpu_length       (o_tpu_length),
    .i_tpu_done         (i_tpu_done),
    .i_tpu_relu_out     (relu),
    .o_out_valid        (o_out_valid),
    .i_out_ready        (i_out_ready),
    .o_out_data         (o_out_data),
    .o_out_index        (o_out_index)
  );

  typedef struct {
    int k;
    int rdy_mode;
    int exp_err;
    int exp_outs;
    int exp_starts;
    int exp_len;
    int batch0;
  } job_vec_t;

  job_vec_t   vecs[6];
  int         batch_addr[4][9];
  logic [8:0] batch_act[4];

  int n_checks = 0;
  int n_errors = 0;
  int cur_batch = 0, job_batch = 0, starts = 0, out_cnt = 0;
  int done_cnt = 0, err_cnt = 0, rdy_mode = 0, exp_len = 0, exp_k = 0;
  int exp_kbase = 0, exp_bbase = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stub TPU: checks the programmed batch at each start, answers with done three cycles later.
  initial begin
    stub_done = 1'b0;
    relu = '0;
    forever begin
      @(negedge clk);
      if (o_tpu_start === 1'b1) begin
        starts++;
        chk("tpu_length", o_tpu_length, exp_len);
        chk("tpu_kernel_dim", o_tpu_kernel_dim, exp_k);
        if (cur_batch < 4) begin
          chk("active_mask", o_active, batch_act[cur_batch]);
          for (int i = 0; i < NU; i++) begin
            chk("start_addr_1", o_addr1[i], batch_addr[cur_batch][i]);
            chk("start_addr_2", o_addr2[i], batch_act[cur_batch][i] ? exp_kbase : 0);
            chk("bias_addr", o_bias[i], batch_act[cur_batch][i] ? exp_bbase : 0);
          end
        end else begin
          chk("batch_overrun", cur_batch, 3);
        end
        cur_batch++;
        for (int i = 0; i < NU; i++) relu[i] = DW'(100 + i + 20 * job_batch);
        job_batch++;
        @(negedge clk);
        chk("tpu_start_width", o_tpu_start, 0);
        repeat (2) @(negedge clk);
        stub_done = 1'b1;
        @(negedge clk);
        stub_done = 1'b0;
      end
    end
  end

  // Sink: drives ready, checks result order/data, stall stability and pulse counts.
  initial begin
    logic [3:0]    pat;
    logic          held_stall;
    logic [DW-1:0] held_data;
    logic [AW-1:0] held_idx;
    pat = 4'b1001;
    held_stall = 1'b0;
    held_data = '0;
    held_idx = '0;
    i_out_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      i_out_ready = (rdy_mode == 1) ? pat[cyc % 4] : 1'b1;
      if (held_stall) begin
        chk("stall_valid", o_out_valid, 1);
        chk("stall_data", o_out_data, held_data);
        chk("stall_index", o_out_index, held_idx);
      end
      held_stall = o_out_valid && !i_out_ready;
      held_data  = o_out_data;
      held_idx   = o_out_index;
      if (o_out_valid && i_out_ready) begin
        chk("out_index", o_out_index, out_cnt);
        chk("out_data", o_out_data, 100 + (out_cnt % 9) + 20 * (out_cnt / 9));
        out_cnt++;
      end
      if (o_job_done === 1'b1) done_cnt++;
      if (o_job_error === 1'b1) err_cnt++;
    end
  end

  task automatic arm(input int k, input int batch0, input int len, input int kb, input int bb);
    exp_k = k; cur_batch = batch0; exp_len = len; exp_kbase = kb; exp_bbase = bb;
    job_batch = 0; starts = 0; out_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  task automatic pulse_start(input int k, input int kb, input int bb);
    i_job_start = 1'b1;
    i_job_kernel_dim = KW'(k);
    i_job_kernel_base = AW'(kb);
    i_job_bias_base = AW'(bb);
    @(negedge clk);
    i_job_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (o_job_done === 1'b1) ok = 1'b1;
    end
    chk("job_done_timeout", ok, 1);
  endtask

  task automatic run_job(input int v);
    bit ok;
    logic busy_seen;
    arm(vecs[v].k, vecs[v].batch0, vecs[v].exp_len, 17 + v, 3 + v);
    rdy_mode = vecs[v].rdy_mode;
    @(negedge clk);
    pulse_start(vecs[v].k, 17 + v, 3 + v);
    if (vecs[v].exp_err != 0) begin
      busy_seen = 1'b0;
      repeat (4) begin
        busy_seen = busy_seen | o_busy;
        @(negedge clk);
      end
      chk("err_pulses", err_cnt, 1);
      chk("err_busy", busy_seen, 0);
    end else begin
      wait_done(ok);
      repeat (2) @(negedge clk);
      chk("done_pulses", done_cnt, 1);
      chk("err_pulses", err_cnt, 0);
      chk("busy_after_done", o_busy, 0);
    end
    chk("tpu_starts", starts, vecs[v].exp_starts);
    chk("out_count", out_cnt, vecs[v].exp_outs);
    rdy_mode = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_job_done"}, o_job_done, 0);
    chk({tag, "_job_error"}, o_job_error, 0);
    chk({tag, "_tpu_start"}, o_tpu_start, 0);
    chk({tag, "_active"}, o_active, 0);
    chk({tag, "_addr1"}, o_addr1, 0);
    chk({tag, "_addr2"}, o_addr2, 0);
    chk({tag, "_bias"}, o_bias, 0);
    chk({tag, "_kdim"}, o_tpu_kernel_dim, 0);
    chk({tag, "_length"}, o_tpu_length, 0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_out_data"}, o_out_data, 0);
    chk({tag, "_out_index"}, o_out_index, 0);
  endtask

  initial begin
    bit   ok;
    logic seen;
    i_reset = 1'b1; i_job_start = 1'b0; i_job_kernel_dim = '0;
    i_job_kernel_base = '0; i_job_bias_base = '0; spur_done = 1'b0;

    batch_addr = '{'{0, 1, 2, 5, 6, 7, 10, 11, 12},
                   '{0, 1, 2, 3, 5, 6, 7, 8, 10},
                   '{11, 12, 13, 15, 16, 17, 18, 0, 0},
                   '{0, 0, 0, 0, 0, 0, 0, 0, 0}};
    batch_act = '{9'h1FF, 9'h1FF, 9'h07F, 9'h001};
    //          k  rdy err outs starts len batch0
    vecs[0] = '{3, 0,  0,  9,   1,     9,  0};
    vecs[1] = '{2, 0,  0,  16,  2,     4,  1};
    vecs[2] = '{5, 0,  0,  1,   1,     25, 3};
    vecs[3] = '{0, 0,  1,  0,   0,     0,  0};
    vecs[4] = '{6, 0,  1,  0,   0,     0,  0};
    vecs[5] = '{3, 1,  0,  9,   1,     9,  0};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    i_reset = 1'b0;
    @(negedge clk);

    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      seen = seen | o_busy | o_out_valid;
      @(negedge clk);
    end
    chk("spurious_done_ignored", seen, 0);

    for (int v = 0; v < 6; v++) run_job(v);

    // Overlap: requests while busy and in the job_done cycle must be dropped.
    arm(3, 0, 9, 9, 4);
    pulse_start(3, 9, 4);
    repeat (2) @(negedge clk);
    pulse_start(2, 30, 30);
    wait_done(ok);
    pulse_start(2, 30, 30);
    seen = 1'b0;
    repeat (4) begin
      seen = seen | o_busy;
      @(negedge clk);
    end
    chk("start_in_done_cycle_ignored", seen, 0);
    chk("overlap_starts", starts, 1);
    chk("overlap_outs", out_cnt, 9);
    chk("overlap_done", done_cnt, 1);

    // Reset while the batch is waiting on the TPU.
    arm(3, 0, 9, 12, 6);
    pulse_start(3, 12, 6);
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (starts > 0) ok = 1'b1;
    end
    chk("wait_start_timeout", ok, 1);
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_all_zero("midjob_reset");
    i_reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | o_busy | o_out_valid;
    end
    chk("after_reset_idle", seen, 0);
    chk("after_reset_no_done", done_cnt, 0);
    chk("after_reset_no_error", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
